// File: rtl/ge_pkg.sv
// ============================================================================
// Module      : ge_pkg
// Description : Shared definitions for the GF(2) Gaussian-elimination array:
//               injector FSM state encoding, node op encodings and a
//               constant-evaluable clog2 helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ge_pkg;

    // Injector FSM state, explicitly 2 bits wide
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2
    } ge_state_e;

    // Node operation encodings shared with the node array
    localparam logic [1:0] OP_PASS = 2'b00;
    localparam logic [1:0] OP_SWAP = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_NOP  = 2'b11;

    // Ceiling log2, usable in localparam expressions; clog2(1) = 0
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage : ge_pkg

`default_nettype wire

// File: rtl/ge_skew_chain.sv
// ============================================================================
// Module      : ge_skew_chain
// Description : DEPTH-stage, enable-gated shift register carrying a (data,
//               start) bit pair for one array column. The last stage drives
//               the column directly, so the column output is registered.
// Ports       : clk, rst      - clock, asynchronous active-high reset
//               i_en          - shift enable (one beat)
//               i_data/i_start- bit pair entering stage 0
//               o_data/o_start- bit pair leaving stage DEPTH-1
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ge_skew_chain #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_data,
    input  logic i_start,
    output logic o_data,
    output logic o_start
);

    logic [DEPTH-1:0] r_data;
    logic [DEPTH-1:0] r_start;

    // Shift-by-one with OR-in works for any DEPTH including 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= '0;
            r_start <= '0;
        end else if (i_en) begin
            r_data  <= (r_data  << 1) | DEPTH'(i_data);
            r_start <= (r_start << 1) | DEPTH'(i_start);
        end
    end

    assign o_data  = r_data[DEPTH-1];
    assign o_start = r_start[DEPTH-1];

endmodule : ge_skew_chain

`default_nettype wire

// File: rtl/ge_row_injector.sv
// ============================================================================
// Module      : ge_row_injector
// Description : Source end of the GF(2) Gaussian-elimination systolic array.
//               Accepts rows over valid/ready, skews them so bit j reaches
//               column j j beats after bit 0, tags the first row of each
//               matrix with a start token, appends N-1 zero-row flush beats
//               and pulses done when the skew tail has drained.
// Config      : `define ROWCNT_CHECK_EN to enable the row-count checker that
//               drives err; otherwise err is tied low.
// Ports       : clk, rst           - clock, asynchronous active-high reset
//               in_valid/in_ready  - row handshake
//               in_row[N-1:0]      - row bits, bit j for column j
//               in_last            - final row of the matrix
//               array_en           - array advance enable (one beat)
//               col_data[N-1:0]    - skewed column data
//               col_start[N-1:0]   - skewed column start tokens
//               done               - one-cycle completion pulse
//               err                - sticky row-count mismatch flag
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ge_row_injector
    import ge_pkg::*;
#(
    parameter int N = 8,
    parameter int M = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_row,
    input  logic         in_last,
    output logic         array_en,
    output logic [N-1:0] col_data,
    output logic [N-1:0] col_start,
    output logic         done,
    output logic         err
);

    // Flush counter spans 0..N-1; keep it at least one bit wide for N=1
    localparam int c_fcnt_w = (N > 1) ? clog2(N) : 1;
    localparam logic [c_fcnt_w-1:0] c_flush_last = c_fcnt_w'(N - 1);

    ge_state_e           r_state;
    ge_state_e           w_state_nxt;
    logic [c_fcnt_w-1:0] r_flush_cnt;
    logic                r_array_en;
    logic                r_done;

    logic                w_accept;
    logic                w_flush_end;
    logic                w_flush_beat;
    logic                w_shift;
    logic [N-1:0]        w_feed_data;
    logic [N-1:0]        w_feed_start;

    assign w_accept    = in_valid & in_ready;
    // FLUSH lasts N cycles: N-1 shifting cycles, then one cycle in which the
    // final flush beat is presented to the array before done is raised.
    assign w_flush_end = (r_flush_cnt == c_flush_last);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, STREAM: begin
                if (w_accept) begin
                    w_state_nxt = in_last ? FLUSH : STREAM;
                end
            end
            FLUSH: begin
                if (w_flush_end) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath control
    // ------------------------------------------------------------------
    always_comb begin
        in_ready     = 1'b1;
        w_flush_beat = 1'b0;
        w_feed_data  = in_row;
        w_feed_start = '0;
        case (r_state)
            IDLE: begin
                // First row of a matrix carries the start token in every column
                w_feed_start = {N{1'b1}};
            end
            STREAM: begin
                w_feed_start = '0;
            end
            FLUSH: begin
                in_ready     = 1'b0;
                w_flush_beat = ~w_flush_end;
                w_feed_data  = '0;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // A stalled input produces no beat, so every chain holds its alignment
    assign w_shift = w_accept | w_flush_beat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush_cnt <= '0;
            r_array_en  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_array_en <= w_shift;
            r_done     <= (r_state == FLUSH) & w_flush_end;
            if (r_state != FLUSH) begin
                r_flush_cnt <= '0;
            end else if (!w_flush_end) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign array_en = r_array_en;
    assign done     = r_done;

    // ------------------------------------------------------------------
    // Per-column skew chains: column j is j+1 stages deep
    // ------------------------------------------------------------------
    for (genvar j = 0; j < N; j++) begin : g_col
        ge_skew_chain #(
            .DEPTH(j + 1)
        ) u_chain (
            .clk    (clk),
            .rst    (rst),
            .i_en   (w_shift),
            .i_data (w_feed_data[j]),
            .i_start(w_feed_start[j]),
            .o_data (col_data[j]),
            .o_start(col_start[j])
        );
    end

    // ------------------------------------------------------------------
    // Optional row-count checker
    // ------------------------------------------------------------------
`ifdef ROWCNT_CHECK_EN
    localparam int c_cnt_w = clog2(M + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = {c_cnt_w{1'b1}};
    localparam logic [c_cnt_w-1:0] c_rows_exp = c_cnt_w'(M);

    logic [c_cnt_w-1:0] r_row_cnt;
    logic [c_cnt_w-1:0] w_row_cnt_nxt;
    logic               r_err;

    // Count including the row being accepted; saturates instead of wrapping
    always_comb begin
        w_row_cnt_nxt = r_row_cnt;
        if (r_state == IDLE) begin
            w_row_cnt_nxt = c_cnt_w'(1);
        end else if (r_row_cnt != c_cnt_max) begin
            w_row_cnt_nxt = r_row_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row_cnt <= '0;
            r_err     <= 1'b0;
        end else if (w_accept) begin
            r_row_cnt <= w_row_cnt_nxt;
            if (in_last && (w_row_cnt_nxt != c_rows_exp)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    // M only sizes the checker; without it err is tied low
    localparam bit c_m_legal = (M >= 1);
    assign err = 1'b0 & c_m_legal;
`endif

endmodule : ge_row_injector

`default_nettype wire

// File: tb/tb_ge_row_injector.sv
// ============================================================================
// Module      : tb_ge_row_injector
// Description : Self-checking bench for ge_row_injector. Instance A (N=4,
//               M=4) runs directed and randomized matrices against a beat-
//               level reference model; instance B (N=1, M=2) covers the
//               zero-flush corner case.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ge_row_injector;

    localparam int NA = 4;
    localparam int MA = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic          a_in_valid, a_in_ready, a_in_last, a_array_en, a_done, a_err;
    logic [NA-1:0] a_in_row, a_col_data, a_col_start;

    logic       b_in_valid, b_in_ready, b_in_last, b_array_en, b_done, b_err;
    logic [0:0] b_in_row, b_col_data, b_col_start;

    ge_row_injector #(.N(NA), .M(MA)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_row(a_in_row), .in_last(a_in_last),
        .array_en(a_array_en), .col_data(a_col_data), .col_start(a_col_start),
        .done(a_done), .err(a_err)
    );

    ge_row_injector #(.N(1), .M(2)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_row(b_in_row), .in_last(b_in_last),
        .array_en(b_array_en), .col_data(b_col_data), .col_start(b_col_start),
        .done(b_done), .err(b_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // ---------------- reference model for instance A ----------------
    // A matrix is the list of accepted rows; beat t of the matrix shows
    // column j the bit j of row t-j (zero outside the row list), and the
    // start token on column j only at beat t==j.
    logic [NA-1:0] m_rows[$];
    logic [NA-1:0] s_rows[$];
    int  m_t         = 0;
    bit  m_prev_acc  = 1'b0;
    bit  m_after_last = 1'b0;
    int  m_since     = 0;
    bit  m_err       = 1'b0;
    bit  m_cur_ready = 1'b1;
    bit  m_done_seen = 1'b0;

    task automatic model_clear();
        m_rows.delete();
        m_t = 0; m_prev_acc = 1'b0; m_after_last = 1'b0; m_since = 0;
        m_cur_ready = 1'b1; m_done_seen = 1'b0;
    endtask

    task automatic check_a();
        logic [NA-1:0] ed, es;
        int  idx;
        bit  in_flush, e_en, e_done;
        @(negedge clk);
        if (m_after_last) m_since++;
        // After the last row: N beats (1 from the row itself, N-1 flush), then done
        in_flush = m_after_last && (m_since >= 1) && (m_since <= NA);
        e_en     = m_prev_acc || in_flush;
        e_done   = m_after_last && (m_since == NA + 1);
        chk("a_array_en", 32'(a_array_en), 32'(e_en));
        chk("a_in_ready", 32'(a_in_ready), 32'(!in_flush));
        chk("a_done",     32'(a_done),     32'(e_done));
        chk("a_err",      32'(a_err),      32'(m_err));
        if (e_en && a_array_en) begin
            ed = '0; es = '0;
            for (int j = 0; j < NA; j++) begin
                idx = m_t - j;
                if (idx >= 0 && idx < m_rows.size()) ed[j] = m_rows[idx][j];
                es[j] = (m_t == j);
            end
            chk("a_col_data",  32'(a_col_data),  32'(ed));
            chk("a_col_start", 32'(a_col_start), 32'(es));
            m_t++;
        end
        m_cur_ready = !in_flush;
        m_done_seen = e_done;
        if (e_done) begin
            m_rows.delete(); m_t = 0; m_after_last = 1'b0; m_since = 0;
        end
    endtask

    task automatic drive_a(input bit want, input logic [NA-1:0] row, input bit last);
        bit acc;
        a_in_valid = want;
        a_in_row   = want ? row  : NA'($urandom);
        a_in_last  = want ? last : 1'($urandom);
        acc = want && m_cur_ready;
        m_prev_acc = acc;
        if (acc) begin
            m_rows.push_back(row);
            if (last) begin
                m_after_last = 1'b1;
                m_since = 0;
`ifdef ROWCNT_CHECK_EN
                if (m_rows.size() != MA) m_err = 1'b1;
`endif
            end
        end
    endtask

    // Sends k rows (from s_rows, topped up randomly), optional forced gap
    // of gap_len idle cycles after gap_at rows, runs until done.
    task automatic do_matrix(input int k, input int stall_pct, input int gap_at, input int gap_len);
        int  sent, gap, cyc;
        bit  want, fin;
        logic [NA-1:0] row;
        while (s_rows.size() < k) s_rows.push_back(NA'($urandom));
        sent = 0; gap = 0; cyc = 0; fin = 1'b0;
        while (!fin) begin
            if (sent < k && m_cur_ready) begin
                if (sent == gap_at && gap < gap_len) begin
                    want = 1'b0; gap++;
                end else begin
                    want = ($urandom_range(99) >= stall_pct);
                end
            end else if (!m_cur_ready) begin
                want = 1'($urandom);   // offered while flushing; must be refused
            end else begin
                want = 1'b0;
            end
            row = (sent < k) ? s_rows[sent] : '0;
            drive_a(want, row, sent == k - 1);
            if (m_prev_acc) sent++;
            check_a();
            if (m_done_seen && sent == k) fin = 1'b1;
            cyc++;
            if (!fin && cyc > 400) begin
                chk("a_matrix_timeout", 32'd0, 32'd1);
                fin = 1'b1;
            end
        end
        s_rows.delete();
    endtask

    initial begin
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_row = '0; a_in_last = 1'b0;
        b_in_valid = 1'b0; b_in_row = '0; b_in_last = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_a_array_en",  32'(a_array_en),  32'd0);
        chk("rst_a_col_data",  32'(a_col_data),  32'd0);
        chk("rst_a_col_start", 32'(a_col_start), 32'd0);
        chk("rst_a_done",      32'(a_done),      32'd0);
        chk("rst_a_err",       32'(a_err),       32'd0);
        chk("rst_a_in_ready",  32'(a_in_ready),  32'd1);
        chk("rst_b_in_ready",  32'(b_in_ready),  32'd1);

        // ---- N=1: two rows, no flush beats, done right after the 2nd beat
        b_in_valid = 1'b1; b_in_row = 1'b1; b_in_last = 1'b0;
        @(negedge clk);
        chk("b1_array_en", 32'(b_array_en), 32'd1);
        chk("b1_col_data", 32'(b_col_data), 32'd1);
        chk("b1_col_start", 32'(b_col_start), 32'd1);
        chk("b1_done", 32'(b_done), 32'd0);
        b_in_row = 1'b0; b_in_last = 1'b1;
        @(negedge clk);
        chk("b2_array_en", 32'(b_array_en), 32'd1);
        chk("b2_col_data", 32'(b_col_data), 32'd0);
        chk("b2_col_start", 32'(b_col_start), 32'd0);
        chk("b2_in_ready", 32'(b_in_ready), 32'd0);
        chk("b2_done", 32'(b_done), 32'd0);
        b_in_valid = 1'b0;
        @(negedge clk);
        chk("b3_done", 32'(b_done), 32'd1);
        chk("b3_array_en", 32'(b_array_en), 32'd0);
        chk("b3_in_ready", 32'(b_in_ready), 32'd1);
        @(negedge clk);
        chk("b4_done", 32'(b_done), 32'd0);
        chk("b4_err", 32'(b_err), 32'd0);

        // ---- directed walking-one matrix, no stalls
        s_rows = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        do_matrix(4, 0, -1, 0);
        // ---- same rows with a 2-cycle input gap between rows 2 and 3
        s_rows = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        do_matrix(4, 0, 2, 2);
        // ---- single-row matrix straight to FLUSH
        s_rows = '{4'b1011};
        do_matrix(1, 0, -1, 0);
        // ---- back-to-back: first row offered in the done cycle
        do_matrix(4, 0, -1, 0);

        // ---- reset after 2 of 4 rows
        drive_a(1'b1, 4'b1111, 1'b0); check_a();
        drive_a(1'b1, 4'b0110, 1'b0); check_a();
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_array_en",  32'(a_array_en),  32'd0);
        chk("mid_rst_col_data",  32'(a_col_data),  32'd0);
        chk("mid_rst_col_start", 32'(a_col_start), 32'd0);
        chk("mid_rst_done",      32'(a_done),      32'd0);
        chk("mid_rst_err",       32'(a_err),       32'd0);
        model_clear();
        m_err = 1'b0;
        a_in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(a_in_ready), 32'd1);
        s_rows = '{4'b1001, 4'b0101, 4'b0011, 4'b1110};
        do_matrix(4, 0, -1, 0);

        // ---- short matrix (row-count mismatch when the checker is built in)
        do_matrix(3, 0, -1, 0);

        // ---- randomized matrices with random stalls
        for (int n = 0; n < 25; n++) begin
            do_matrix($urandom_range(7, 1), 30, -1, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_ge_row_injector

`default_nettype wire
